// File: rtl/widget2_rx.sv
// ---------------------------------------------------------------------------
// widget2_rx
// Serial receiver for the widget2 1-bit data stream. One line bit is sampled
// per clock. A frame is: start bit (0), DATA_W data bits LSB first, an
// optional even-parity bit, and a stop bit (1). Good frames are loaded into a
// single holding register that is drained with a valid/ready handshake.
//
// Parameters
//   DATA_W     data bits per frame (5..16)
//   PARITY_EN  1 = frame carries an even-parity bit, 0 = no parity bit
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous, active-low reset
//   data_in     serial line, idle high, one bit per cycle
//   data_out    received word, meaningful while data_valid = 1
//   data_valid  holding register contains an unconsumed word
//   data_ready  consumer accepts the word when data_valid & data_ready
//   parity_err  one-cycle pulse: frame discarded for bad parity
//   frame_err   one-cycle pulse: frame discarded for a 0 stop bit
//   overrun     one-cycle pulse: good frame dropped, holding register full
// ---------------------------------------------------------------------------
module widget2_rx #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic [DATA_W-1:0]   shift_in;
    // Running XOR of the data bits and (when present) the parity bit;
    // a 1 at the stop bit means the even-parity check failed.
    logic                par_acc_reg, par_acc_next;

    logic [DATA_W-1:0]   data_out_reg, data_out_next;
    logic                data_valid_reg, data_valid_next;
    logic                parity_err_reg, parity_err_next;
    logic                frame_err_reg, frame_err_next;
    logic                overrun_reg, overrun_next;

    logic                par_bad;
    logic                good_frame;
    logic                load_word;

    // LSB-first shifting: new bit enters at the top, so after DATA_W shifts
    // the first received bit sits in bit 0.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
            if (gi == DATA_W - 1) begin : g_top
                assign shift_in[gi] = data_in;
            end else begin : g_mid
                assign shift_in[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            shift_reg      <= '0;
            par_acc_reg    <= 1'b0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            shift_reg      <= shift_next;
            par_acc_reg    <= par_acc_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
            overrun_reg    <= overrun_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        shift_next   = shift_reg;
        par_acc_next = par_acc_reg;
        case (state_reg)
            S_IDLE: begin
                if (!data_in) begin
                    state_next   = S_DATA;
                    cnt_next     = '0;
                    par_acc_next = 1'b0;
                end
            end
            S_DATA: begin
                shift_next   = shift_in;
                par_acc_next = par_acc_reg ^ data_in;
                cnt_next     = cnt_reg + 1'b1;
                if (cnt_reg == LAST_BIT) begin
                    cnt_next   = '0;
                    state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                par_acc_next = par_acc_reg ^ data_in;
                state_next   = S_STOP;
            end
            S_STOP: begin
                state_next = data_in ? S_IDLE : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (data_in) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: frame verdict on the stop-bit edge plus the handshake
    always_comb begin
        par_bad    = (PARITY_EN != 0) && par_acc_reg;
        good_frame = (state_reg == S_STOP) && data_in && !par_bad;
        // A full holding register can still take a new word if it is being
        // drained on this very edge.
        load_word  = good_frame && (!data_valid_reg || data_ready);

        data_out_next   = data_out_reg;
        data_valid_next = data_valid_reg;
        if (load_word) begin
            data_out_next   = shift_reg;
            data_valid_next = 1'b1;
        end else if (data_valid_reg && data_ready) begin
            data_valid_next = 1'b0;
        end

        // A 0 stop bit masks any parity verdict, keeping the pulses exclusive.
        frame_err_next  = (state_reg == S_STOP) && !data_in;
        parity_err_next = (state_reg == S_STOP) && data_in && par_bad;
        overrun_next    = good_frame && data_valid_reg && !data_ready;
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_widget2_rx.sv
// ---------------------------------------------------------------------------
// tb_widget2_rx
// Drives widget2 frames bit by bit and compares every cycle's outputs with a
// transaction-level model: a single holding register plus the frame verdict
// (good / bad parity / bad stop) known from how each frame was built.
// ---------------------------------------------------------------------------
module tb_widget2_rx;

    localparam int DW = 8;
    localparam int PE = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          data_in = 1'b1;
    logic          data_ready = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data  = '0;
    logic          exp_pe = 1'b0, exp_fe = 1'b0, exp_ov = 1'b0;

    localparam int EV_NONE = 0, EV_GOOD = 1, EV_BADPAR = 2, EV_BADSTOP = 3;

    widget2_rx #(.DATA_W(DW), .PARITY_EN(PE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("data_valid", 32'(data_valid), 32'(exp_valid));
        if (exp_valid) check_eq("data_out", 32'(data_out), 32'(exp_data));
        check_eq("parity_err", 32'(parity_err), 32'(exp_pe));
        check_eq("frame_err", 32'(frame_err), 32'(exp_fe));
        check_eq("overrun", 32'(overrun), 32'(exp_ov));
    endtask

    function automatic logic pick_rdy(input int mode);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return (mode != 0);
    endfunction

    // One line bit per cycle; ev tells the model what this edge completes.
    task automatic drive_bit(input logic b, input logic rdy, input int ev, input logic [DW-1:0] word);
        logic accept;
        @(negedge clk);
        data_in    = b;
        data_ready = rdy;
        @(posedge clk);
        accept = exp_valid && rdy;
        exp_pe = 1'b0;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        if (ev == EV_GOOD && (!exp_valid || rdy)) begin
            exp_data  = word;
            exp_valid = 1'b1;
        end else begin
            if (ev == EV_GOOD) exp_ov = 1'b1;
            if (ev == EV_BADPAR) exp_pe = 1'b1;
            if (ev == EV_BADSTOP) exp_fe = 1'b1;
            if (accept) exp_valid = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input logic bad_par, input logic bad_stop,
                              input int rdy_mode, input int stop_rdy_mode);
        int ev;
        ev = bad_stop ? EV_BADSTOP : (bad_par && PE != 0) ? EV_BADPAR : EV_GOOD;
        drive_bit(1'b0, pick_rdy(rdy_mode), EV_NONE, w);
        for (int i = 0; i < DW; i++) drive_bit(w[i], pick_rdy(rdy_mode), EV_NONE, w);
        if (PE != 0) drive_bit((^w) ^ bad_par, pick_rdy(rdy_mode), EV_NONE, w);
        drive_bit(!bad_stop, pick_rdy(stop_rdy_mode), ev, w);
        $display("frame 0x%02h bad_par=%0d bad_stop=%0d -> valid=%0d out=0x%02h pe=%0d fe=%0d ov=%0d",
                 w, bad_par, bad_stop, data_valid, data_out, parity_err, frame_err, overrun);
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_pe    = 1'b0;
        exp_fe    = 1'b0;
        exp_ov    = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] w;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data_out", 32'(data_out), 32'h0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic good frame 0xA5, then drained
        send_frame(8'hA5, 1'b0, 1'b0, 1, 1);
        drive_bit(1'b1, 1'b1, EV_NONE, '0);

        // Bad parity
        send_frame(8'hA5, 1'b1, 1'b0, 1, 1);
        drive_bit(1'b1, 1'b1, EV_NONE, '0);

        // Bad stop, line held low, then recovery
        send_frame(8'h3C, 1'b0, 1'b1, 1, 1);
        for (int i = 0; i < 5; i++) drive_bit(1'b0, 1'b1, EV_NONE, '0);
        drive_bit(1'b1, 1'b1, EV_NONE, '0);
        send_frame(8'h3C, 1'b0, 1'b0, 1, 1);
        drive_bit(1'b1, 1'b1, EV_NONE, '0);

        // Overrun: two back-to-back frames, consumer stalled
        send_frame(8'h11, 1'b0, 1'b0, 0, 0);
        send_frame(8'h22, 1'b0, 1'b0, 0, 0);
        drive_bit(1'b1, 1'b1, EV_NONE, '0);
        drive_bit(1'b1, 1'b1, EV_NONE, '0);

        // Accept on the same edge a new good frame completes
        send_frame(8'h11, 1'b0, 1'b0, 0, 0);
        send_frame(8'h22, 1'b0, 1'b0, 0, 1);
        drive_bit(1'b1, 1'b0, EV_NONE, '0);
        drive_bit(1'b1, 1'b1, EV_NONE, '0);

        // Reset during data bit 4 with a word held
        send_frame(8'h33, 1'b0, 1'b0, 0, 0);
        w = 8'h5A;
        drive_bit(1'b0, 1'b0, EV_NONE, w);
        for (int i = 0; i < 4; i++) drive_bit(w[i], 1'b0, EV_NONE, w);
        @(negedge clk);
        data_in = w[4];
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_mid_data_out", 32'(data_out), 32'h0);
        check_outputs();
        @(negedge clk);
        data_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 1, 1);
        drive_bit(1'b1, 1'b1, EV_NONE, '0);

        // Randomized traffic
        for (int f = 0; f < 200; f++) begin
            logic bp, bs;
            w  = DW'($urandom);
            bp = ($urandom_range(0, 7) == 0);
            bs = ($urandom_range(0, 7) == 0);
            send_frame(w, bp, bs, 2, 2);
            if (bs) begin
                int nz;
                nz = $urandom_range(0, 3);
                for (int i = 0; i < nz; i++) drive_bit(1'b0, pick_rdy(2), EV_NONE, '0);
                drive_bit(1'b1, pick_rdy(2), EV_NONE, '0);
            end
            begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int i = 0; i < gap; i++) drive_bit(1'b1, pick_rdy(2), EV_NONE, '0);
            end
        end
        drive_bit(1'b1, 1'b1, EV_NONE, '0);
        drive_bit(1'b1, 1'b1, EV_NONE, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/widget2_rx.md
WIDGET2_RX -- requirements
Module: widget2_rx

Interface
REQ-001 The block SHALL be the serial receiver for the widget2 1-bit data stream, deframing it into parallel words.
REQ-002 Parameter DATA_W, default 8: data bits per frame, legal range 5..16.
REQ-003 Parameter PARITY_EN, default 1: 1 = frame carries an even-parity bit, 0 = no parity bit.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 data_in  in  1  serial line, synchronous to clk, one bit per cycle, idle high.
REQ-008 data_out  out  DATA_W  received word; valid only while data_valid=1.
REQ-009 data_valid  out  1  data_out holds an unconsumed word.
REQ-010 data_ready  in  1  consumer accepts the word when data_valid=1 and data_ready=1 at a clock edge.
REQ-011 parity_err  out  1  one-cycle pulse: frame discarded for bad parity.
REQ-012 frame_err  out  1  one-cycle pulse: frame discarded for stop bit = 0.
REQ-013 overrun  out  1  one-cycle pulse: good frame dropped because the holding register was full.

Function
REQ-014 Frame format SHALL be: start bit (0), DATA_W data bits LSB first, parity bit (only if PARITY_EN=1), stop bit (1).
REQ-015 Parity SHALL be even: XOR of the data bits and the parity bit equals 0.
REQ-016 FSM states SHALL be IDLE, DATA, PARITY, STOP, WAIT_IDLE.
REQ-017 IDLE: data_in=0 sampled -> DATA with bit counter = 0; data_in=1 -> stay in IDLE.
REQ-018 DATA: shift in one bit per edge; after DATA_W bits -> PARITY if PARITY_EN=1, else -> STOP.
REQ-019 PARITY: sample the parity bit and record the parity result -> STOP.
REQ-020 STOP, sampled data_in=1 -> IDLE; the frame is good unless parity failed.
REQ-021 STOP, sampled data_in=0 -> WAIT_IDLE and pulse frame_err; frame_err takes precedence over parity_err, so parity_err is not pulsed.
REQ-022 WAIT_IDLE: stay until data_in=1 is sampled, then -> IDLE; a 0 on the line is never treated as a start bit in this state.
REQ-023 Good frame: data_out and data_valid SHALL update on the same edge that samples the stop bit (latency 0 cycles after the stop-bit edge).
REQ-024 Parity failure: the frame SHALL be discarded; parity_err pulses on the stop-bit edge; data_out and data_valid are unchanged.
REQ-025 Frame length SHALL be DATA_W+2+PARITY_EN cycles; back-to-back frames with no idle bit between them SHALL be received.
REQ-026 Handshake: data_valid stays 1 and data_out stays stable until accepted; on acceptance data_valid clears on that edge unless a new good frame loads on the same edge.
REQ-027 Simultaneous acceptance and good-frame completion: the new word SHALL load, data_valid stays 1, and overrun SHALL NOT pulse.
REQ-028 Good frame completing while data_valid=1 and data_ready=0: the new word SHALL be dropped, the old word kept, and overrun pulses for one cycle.
REQ-029 data_ready SHALL be ignored while data_valid=0.
REQ-030 Error pulses SHALL be exactly one cycle wide and mutually exclusive within a cycle.

Reset
REQ-031 rst_n=0 SHALL asynchronously force: FSM=IDLE, bit counter=0, shift register=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no output or error pulse; after release the block waits in IDLE for a start bit.
REQ-033 After rst_n deasserts, the first edge SHALL be able to sample a start bit.

Verification
REQ-034 DATA_W=8, PARITY_EN=1, data_ready=1: serial 0,1,0,1,0,0,1,0,1,0,1 -> data_out=0xA5 and data_valid=1 for one cycle after the stop-bit edge; no error pulses.
REQ-035 Same frame with the parity bit set to 1 -> parity_err pulses for 1 cycle; data_valid stays 0.
REQ-036 Frame 0x3C with stop bit 0, then line held 0 for 5 cycles, then 1 -> frame_err pulses once; no start bit is detected until the line returns to 1; a following frame 0x3C is received correctly.
REQ-037 data_ready=0, two back-to-back good frames 0x11 and 0x22 -> data_out=0x11 is held and overrun pulses at the second stop-bit edge; then data_ready=1 -> word accepted and data_valid=0.
REQ-038 Words 0x11 and 0x22 back to back, with data_ready asserted on the second frame's stop-bit edge -> data_out=0x22, data_valid stays 1, no overrun pulse.
REQ-039 rst_n pulsed low during data bit 4 of a frame -> all outputs read 0 immediately; the next complete frame 0x5A is received correctly.
